// File: rtl/io_bridge_pkg.sv
// Shared constants for the minisys-32 IO bridge: word width, IO region base
// and word indices (addr[9:2]) of the memory-mapped peripheral registers.
package io_bridge_pkg;

  localparam int          ISA_WIDTH       = 32;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  // Word indices; byte offsets are 0x60, 0x64, ... 0x78 from IO_BASE
  localparam logic [7:0] IO_LED     = 8'h18;
  localparam logic [7:0] IO_LED_SET = 8'h19;
  localparam logic [7:0] IO_LED_CLR = 8'h1A;
  localparam logic [7:0] IO_LED_TGL = 8'h1B;
  localparam logic [7:0] IO_SW      = 8'h1C;
  localparam logic [7:0] IO_SW_CHG  = 8'h1D;
  localparam logic [7:0] IO_TIMER   = 8'h1E;

endpackage

// File: rtl/io_bridge_sw_debounce.sv
// One switch bit: 2-FF synchroniser, stability counter and debounced output,
// with a single-cycle changed pulse coincident with the output update.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic stable_o,
  output logic changed_o
);

  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             changed_s;

  // Restart when the value entering the synchronised flop differs from it,
  // so the update lands exactly 2 + DEBOUNCE_CYCLES edges after a raw edge.
  always_comb begin
    cnt_d     = cnt_q;
    changed_s = (cnt_q == CNT_MAX) && (meta_q == sync_q) && (sync_q != stable_q);
    if (meta_q != sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    stable_d = changed_s ? sync_q : stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q   <= sw_i;
      sync_q   <= meta_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o  = stable_q;
  assign changed_o = changed_s;

endmodule

// File: rtl/io_bridge.sv
// Memory/IO bridge: IO decode, LED register with set/clear/toggle aliases,
// debounced switches with sticky change flags, free-running timer, read mux.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int          DATA_WIDTH      = ISA_WIDTH,
  parameter int          SW_WIDTH        = 16,
  parameter int          LED_WIDTH       = 16,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] IO_BASE         = IO_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mRead,
  input  logic                  mWrite,
  input  logic                  ioRead,
  input  logic                  ioWrite,
  input  logic [DATA_WIDTH-1:0] addr_in,
  output logic [DATA_WIDTH-1:0] addr_out,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [DATA_WIDTH-1:0] r_rdata,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] r_wdata,
  input  logic [SW_WIDTH-1:0]   switch,
  output logic [LED_WIDTH-1:0]  led
);

  logic                  is_io_s;
  logic [7:0]            off_s;
  logic [LED_WIDTH-1:0]  led_q;
  logic [LED_WIDTH-1:0]  led_d;
  logic [SW_WIDTH-1:0]   sw_chg_q;
  logic [SW_WIDTH-1:0]   sw_chg_d;
  logic [SW_WIDTH-1:0]   sw_chg_clr_s;
  logic [SW_WIDTH-1:0]   sw_stable_s;
  logic [SW_WIDTH-1:0]   sw_changed_s;
  logic [DATA_WIDTH-1:0] timer_q;
  logic [DATA_WIDTH-1:0] timer_d;
  logic [DATA_WIDTH-1:0] io_rdata_s;

  assign is_io_s = (addr_in[31:10] == IO_BASE[31:10]);
  assign off_s   = addr_in[9:2];

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .sw_i     (switch[g]),
      .stable_o (sw_stable_s[g]),
      .changed_o(sw_changed_s[g])
    );
  end

  // Register write decode; a new change event outranks a same-cycle clear.
  always_comb begin
    led_d        = led_q;
    sw_chg_clr_s = '0;
    timer_d      = timer_q + DATA_WIDTH'(1);
    if (ioWrite && is_io_s) begin
      case (off_s)
        IO_LED:     led_d = r_rdata[LED_WIDTH-1:0];
        IO_LED_SET: led_d = led_q | r_rdata[LED_WIDTH-1:0];
        IO_LED_CLR: led_d = led_q & ~r_rdata[LED_WIDTH-1:0];
        IO_LED_TGL: led_d = led_q ^ r_rdata[LED_WIDTH-1:0];
        IO_SW_CHG:  sw_chg_clr_s = r_rdata[SW_WIDTH-1:0];
        IO_TIMER:   timer_d = r_rdata;
        default:    led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end
    sw_chg_d = (sw_chg_q & ~sw_chg_clr_s) | sw_changed_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      sw_chg_q <= '0;
      timer_q  <= '0;
    end else begin
      led_q    <= led_d;
      sw_chg_q <= sw_chg_d;
      timer_q  <= timer_d;
    end
  end

  // Zero-extended IO read mux and write-back selection.
  always_comb begin
    io_rdata_s = '0;
    if (is_io_s) begin
      case (off_s)
        IO_LED, IO_LED_SET, IO_LED_CLR, IO_LED_TGL: io_rdata_s[LED_WIDTH-1:0] = led_q;
        IO_SW:     io_rdata_s[SW_WIDTH-1:0] = sw_stable_s;
        IO_SW_CHG: io_rdata_s[SW_WIDTH-1:0] = sw_chg_q;
        IO_TIMER:  io_rdata_s = timer_q;
        default:   io_rdata_s = '0;
      endcase
    end else begin
      io_rdata_s = '0;
    end
    if (mRead) begin
      r_wdata = m_rdata;
    end else if (ioRead) begin
      r_wdata = io_rdata_s;
    end else begin
      r_wdata = '0;
    end
    write_data = (mWrite || ioWrite) ? r_rdata : '0;
  end

  assign addr_out = addr_in;
  assign led      = led_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed steps followed by a randomized
// phase checked against a behavioural model of the IO register map.
module tb_io_bridge;

  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mRead = 1'b0, mWrite = 1'b0, ioRead = 1'b0, ioWrite = 1'b0;
  logic [31:0] addr_in = 32'h0, addr_out, m_rdata = 32'h0, r_rdata = 32'h0;
  logic [31:0] write_data, r_wdata;
  logic [15:0] switch = 16'h0, led;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_led, m_sw, m_chg;
  logic [31:0] m_timer;
  logic [15:0] m_hist [0:DEB];

  always #5 clk = ~clk;

  io_bridge #(
    .DATA_WIDTH(32), .SW_WIDTH(16), .LED_WIDTH(16),
    .DEBOUNCE_CYCLES(DEB), .IO_BASE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead),
    .ioWrite(ioWrite), .addr_in(addr_in), .addr_out(addr_out),
    .m_rdata(m_rdata), .r_rdata(r_rdata), .write_data(write_data),
    .r_wdata(r_wdata), .switch(switch), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if ((a >> 10) != (BASE >> 10)) return 32'h0;
    case (a & 32'h0000_03FC)
      32'h060, 32'h064, 32'h068, 32'h06C: return {16'h0, m_led};
      32'h070: return {16'h0, m_sw};
      32'h074: return {16'h0, m_chg};
      32'h078: return m_timer;
      default: return 32'h0;
    endcase
  endfunction

  // A switch bit is accepted once its last DEB+1 raw samples agree.
  task automatic tick();
    logic [15:0] same, set, d16, sample;
    logic [31:0] off;
    logic        wr;
    logic [15:0] n_led, n_sw, n_chg;
    logic [31:0] n_timer;
    sample = switch;
    wr     = ioWrite && ((addr_in >> 10) == (BASE >> 10));
    off    = addr_in & 32'h0000_03FC;
    d16    = r_rdata[15:0];
    same   = 16'hFFFF;
    for (int k = 1; k <= DEB; k++) same &= ~(m_hist[k] ^ m_hist[0]);
    set    = same & (m_hist[0] ^ m_sw);
    n_sw   = m_sw ^ set;
    n_led  = m_led;
    if (wr && off == 32'h060) n_led = d16;
    if (wr && off == 32'h064) n_led = m_led | d16;
    if (wr && off == 32'h068) n_led = m_led & ~d16;
    if (wr && off == 32'h06C) n_led = m_led ^ d16;
    n_chg   = (m_chg & ~((wr && off == 32'h074) ? d16 : 16'h0)) | set;
    n_timer = (wr && off == 32'h078) ? r_rdata : m_timer + 32'd1;
    @(posedge clk);
    if (rst) begin
      m_led = 16'h0; m_sw = 16'h0; m_chg = 16'h0; m_timer = 32'h0;
      for (int k = 0; k <= DEB; k++) m_hist[k] = 16'h0;
    end else begin
      m_led = n_led; m_sw = n_sw; m_chg = n_chg; m_timer = n_timer;
      for (int k = DEB; k >= 1; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = sample;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ioRead = 1'b1; addr_in = a;
    #1;
    chk(tag, r_wdata, exp);
    ioRead = 1'b0;
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
    ioWrite = 1'b1; addr_in = a; r_rdata = d;
    #1;
    chk("write_data_io", write_data, d);
    tick();
    ioWrite = 1'b0;
  endtask

  initial begin
    int offs [10] = '{32'h060, 32'h064, 32'h068, 32'h06C, 32'h070,
                      32'h074, 32'h078, 32'h040, 32'h07C, 32'h000};
    int acc;

    ticks(2);
    rst = 1'b0;
    chk("reset_led", {16'h0, led}, 32'h0);
    rd_chk("reset_sw", 32'hFFFF_FC70, 32'h0);
    rd_chk("reset_chg", 32'hFFFF_FC74, 32'h0);
    rd_chk("reset_timer", 32'hFFFF_FC78, 32'h0);

    io_wr(32'hFFFF_FC60, 32'h0000_A5A5);
    chk("led_write", {16'h0, led}, 32'h0000_A5A5);
    io_wr(32'hFFFF_FC68, 32'h0000_0005);
    chk("led_clr", {16'h0, led}, 32'h0000_A5A0);
    io_wr(32'hFFFF_FC6C, 32'h0000_00FF);
    chk("led_tgl", {16'h0, led}, 32'h0000_A55F);
    io_wr(32'hFFFF_FC64, 32'hFFFF_0000);
    chk("led_set_high_ignored", {16'h0, led}, 32'h0000_A55F);
    rd_chk("led_alias_read", 32'hFFFF_FC6D, 32'h0000_A55F);

    switch = 16'h0003;
    ticks(5);
    rd_chk("sw_latency_early", 32'hFFFF_FC70, 32'h0);
    tick();
    rd_chk("sw_latency_exact", 32'hFFFF_FC70, 32'h0000_0003);
    rd_chk("sw_chg_set", 32'hFFFF_FC74, 32'h0000_0003);
    switch = 16'h0013;
    ticks(2);
    switch = 16'h0003;
    ticks(8);
    rd_chk("sw_glitch", 32'hFFFF_FC70, 32'h0000_0003);
    rd_chk("chg_glitch", 32'hFFFF_FC74, 32'h0000_0003);

    switch = 16'h0002;
    ticks(5);
    io_wr(32'hFFFF_FC74, 32'h0000_0001);
    rd_chk("sw_bit0_fall", 32'hFFFF_FC70, 32'h0000_0002);
    rd_chk("chg_set_wins", 32'hFFFF_FC74, 32'h0000_0003);
    io_wr(32'hFFFF_FC74, 32'h0000_0001);
    rd_chk("chg_clear", 32'hFFFF_FC74, 32'h0000_0002);

    io_wr(32'hFFFF_FC78, 32'hFFFF_FFFE);
    rd_chk("timer_load", 32'hFFFF_FC78, 32'hFFFF_FFFE);
    tick();
    rd_chk("timer_max", 32'hFFFF_FC78, 32'hFFFF_FFFF);
    tick();
    rd_chk("timer_wrap", 32'hFFFF_FC78, 32'h0);

    mRead = 1'b1; addr_in = 32'h0000_0010; m_rdata = 32'h1234_5678;
    #1;
    chk("mread_data", r_wdata, 32'h1234_5678);
    chk("addr_out", addr_out, 32'h0000_0010);
    mRead = 1'b0; r_rdata = 32'hDEAD_BEEF;
    #1;
    chk("write_data_idle", write_data, 32'h0);
    chk("r_wdata_idle", r_wdata, 32'h0);
    rd_chk("io_unmapped", 32'hFFFF_FC40, 32'h0);
    io_wr(32'h0000_0060, 32'h0000_FFFF);
    chk("led_non_io_write", {16'h0, led}, 32'h0000_A55F);

    io_wr(32'hFFFF_FC60, 32'h0000_FFFF);
    chk("led_all_on", {16'h0, led}, 32'h0000_FFFF);
    switch = 16'h0102;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_led", {16'h0, led}, 32'h0);
    rd_chk("rst_sw", 32'hFFFF_FC70, 32'h0);
    rd_chk("rst_chg", 32'hFFFF_FC74, 32'h0);
    rd_chk("rst_timer", 32'hFFFF_FC78, 32'h0);
    switch = 16'h0002;
    ticks(10);
    rd_chk("rst_pending_sw", 32'hFFFF_FC70, 32'h0000_0002);
    rd_chk("rst_pending_chg", 32'hFFFF_FC74, 32'h0000_0002);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) < 2) switch = switch ^ (16'h1 << $urandom_range(0, 15));
      acc = $urandom_range(0, 4);
      mRead   = (acc == 1);
      mWrite  = (acc == 2);
      ioRead  = (acc == 3);
      ioWrite = (acc == 4);
      if ($urandom_range(0, 7) == 0) addr_in = $urandom;
      else addr_in = BASE | 32'(offs[$urandom_range(0, 9)]) | 32'($urandom_range(0, 3));
      m_rdata = $urandom;
      r_rdata = $urandom;
      #1;
      chk("rnd_r_wdata", r_wdata,
          mRead ? m_rdata : (ioRead ? exp_read(addr_in) : 32'h0));
      chk("rnd_write_data", write_data, (mWrite || ioWrite) ? r_rdata : 32'h0);
      chk("rnd_led", {16'h0, led}, {16'h0, m_led});
      tick();
    end
    mRead = 1'b0; mWrite = 1'b0; ioRead = 1'b0; ioWrite = 1'b0;
    rd_chk("final_sw", 32'hFFFF_FC70, {16'h0, m_sw});
    rd_chk("final_chg", 32'hFFFF_FC74, {16'h0, m_chg});
    rd_chk("final_timer", 32'hFFFF_FC78, m_timer);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
